// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one imem request per PC,
// hands {pc, pc+4, inst} to IF/ID and accepts the next PC over a valid/ready handshake.
module ysyx_22040750_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_dnpc_valid,
  output logic        O_dnpc_ready,
  input  logic [31:0] I_dnpc,
  input  logic        I_flush,
  input  logic [31:0] I_flush_pc,
  output logic        O_imem_req_valid,
  input  logic        I_imem_req_ready,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_resp_valid,
  input  logic [31:0] I_imem_rdata,
  output logic        O_IF_ID_valid,
  input  logic        I_IF_ID_ready,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst,
  output logic [63:0] O_fetch_cnt
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        req_fire;
  logic        if_id_fire;
  logic        dnpc_fire;
  logic        outstanding;

  assign O_imem_addr      = pc;
  assign O_imem_req_valid = (state == S_REQ) && !I_rst;
  assign req_fire         = O_imem_req_valid && I_imem_req_ready;
  assign if_id_fire       = (state == S_OUT) && I_IF_ID_ready && !I_flush;
  assign dnpc_fire        = O_dnpc_ready && I_dnpc_valid;

  // A request is still owed a response if it was accepted and its data has not come back.
  assign outstanding = ((state == S_WAIT)  && !I_imem_resp_valid) ||
                       ((state == S_DRAIN) && !I_imem_resp_valid) ||
                       ((state == S_REQ)   && req_fire);

  always_comb begin
    O_dnpc_ready = 1'b0;
    if (!I_rst && !I_flush) begin
      case (state)
        S_OUT:   O_dnpc_ready = I_IF_ID_ready;
        S_IDLE:  O_dnpc_ready = 1'b1;
        default: O_dnpc_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (I_flush) begin
      state_nxt = outstanding ? S_DRAIN : S_REQ;
    end else begin
      case (state)
        S_REQ:   if (req_fire)          state_nxt = S_WAIT;
        S_WAIT:  if (I_imem_resp_valid) state_nxt = S_OUT;
        S_OUT:   if (if_id_fire)        state_nxt = I_dnpc_valid ? S_REQ : S_IDLE;
        S_IDLE:  if (dnpc_fire)         state_nxt = S_REQ;
        S_DRAIN: if (I_imem_resp_valid) state_nxt = S_REQ;
        default:                        state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pc            <= RESET_PC;
      O_IF_ID_valid <= 1'b0;
      O_IF_ID_pc    <= '0;
      O_IF_ID_snpc  <= '0;
      O_IF_ID_inst  <= '0;
      O_fetch_cnt   <= '0;
    end else if (I_flush) begin
      pc            <= I_flush_pc;
      O_IF_ID_valid <= 1'b0;
    end else begin
      if ((state == S_WAIT) && I_imem_resp_valid) begin
        O_IF_ID_valid <= 1'b1;
        O_IF_ID_pc    <= pc;
        O_IF_ID_snpc  <= pc + 32'd4;
        O_IF_ID_inst  <= I_imem_rdata;
      end
      if (if_id_fire) begin
        O_IF_ID_valid <= 1'b0;
        O_fetch_cnt   <= O_fetch_cnt + 64'd1;
      end
      if (dnpc_fire) pc <= I_dnpc;
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_ysyx_22040750_ifu;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_dnpc_valid;
  logic        O_dnpc_ready;
  logic [31:0] I_dnpc;
  logic        I_flush;
  logic [31:0] I_flush_pc;
  logic        O_imem_req_valid;
  logic        I_imem_req_ready;
  logic [31:0] O_imem_addr;
  logic        I_imem_resp_valid;
  logic [31:0] I_imem_rdata;
  logic        O_IF_ID_valid;
  logic        I_IF_ID_ready;
  logic [31:0] O_IF_ID_pc;
  logic [31:0] O_IF_ID_snpc;
  logic [31:0] O_IF_ID_inst;
  logic [63:0] O_fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040750_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_dnpc_valid(I_dnpc_valid), .O_dnpc_ready(O_dnpc_ready), .I_dnpc(I_dnpc),
    .I_flush(I_flush), .I_flush_pc(I_flush_pc),
    .O_imem_req_valid(O_imem_req_valid), .I_imem_req_ready(I_imem_req_ready),
    .O_imem_addr(O_imem_addr), .I_imem_resp_valid(I_imem_resp_valid),
    .I_imem_rdata(I_imem_rdata), .O_IF_ID_valid(O_IF_ID_valid),
    .I_IF_ID_ready(I_IF_ID_ready), .O_IF_ID_pc(O_IF_ID_pc),
    .O_IF_ID_snpc(O_IF_ID_snpc), .O_IF_ID_inst(O_IF_ID_inst),
    .O_fetch_cnt(O_fetch_cnt)
  );

  always #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle_inputs();
    I_dnpc_valid = 0; I_dnpc = '0; I_flush = 0; I_flush_pc = '0;
    I_imem_req_ready = 0; I_imem_resp_valid = 0; I_imem_rdata = '0; I_IF_ID_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    I_rst = 1; I_dnpc_valid = 1; I_IF_ID_ready = 1; I_imem_req_ready = 1;
    tick(); tick(); #1;
    n_checks++; if (O_imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", O_imem_req_valid); end
    n_checks++; if (O_dnpc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dnpc_ready got %b exp 0", O_dnpc_ready); end
    n_checks++; if (O_IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ifid_valid got %b exp 0", O_IF_ID_valid); end
    n_checks++; if ({O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst} !== 96'h0) begin n_fail++; $display("FAIL rst_ifid_regs got %h %h %h exp 0", O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst); end
    n_checks++; if (O_fetch_cnt !== 64'h0) begin n_fail++; $display("FAIL rst_cnt got %h exp 0", O_fetch_cnt); end
    n_checks++; if (O_imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_addr got %h exp 80000000", O_imem_addr); end
    idle_inputs();
    I_rst = 0;
  endtask

  task automatic test_fetch_and_stall();
    logic [31:0] pc_s, inst_s;
    I_imem_req_ready = 1; I_dnpc_valid = 1; I_dnpc = 32'h8000_0010; #1;
    n_checks++; if (O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL first_req got v=%b a=%h exp v=1 a=80000000", O_imem_req_valid, O_imem_addr); end
    tick();
    I_imem_resp_valid = 1; I_imem_rdata = 32'h0000_0413; #1;
    n_checks++; if (O_IF_ID_valid !== 1'b0 || O_imem_req_valid !== 1'b0 || O_dnpc_ready !== 1'b0) begin n_fail++; $display("FAIL wait_outputs got ifv=%b rqv=%b dr=%b exp 0 0 0", O_IF_ID_valid, O_imem_req_valid, O_dnpc_ready); end
    tick();
    I_imem_resp_valid = 0; I_imem_rdata = 32'hFFFF_FFFF; #1;
    n_checks++; if (O_IF_ID_valid !== 1'b1 || O_IF_ID_pc !== 32'h8000_0000 || O_IF_ID_snpc !== 32'h8000_0004 || O_IF_ID_inst !== 32'h0000_0413) begin
      n_fail++; $display("FAIL first_out got v=%b pc=%h snpc=%h inst=%h exp 1 80000000 80000004 00000413", O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst);
    end
    pc_s = O_IF_ID_pc; inst_s = O_IF_ID_inst;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_checks++; if (O_dnpc_ready !== 1'b0 || O_IF_ID_valid !== 1'b1 || O_IF_ID_pc !== pc_s || O_IF_ID_inst !== inst_s || O_fetch_cnt !== 64'd0) begin
        n_fail++; $display("FAIL stall_%0d got dr=%b v=%b pc=%h inst=%h cnt=%0d exp 0 1 %h %h 0", i, O_dnpc_ready, O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_inst, O_fetch_cnt, pc_s, inst_s);
      end
    end
    I_IF_ID_ready = 1; #1;
    n_checks++; if (O_dnpc_ready !== 1'b1) begin n_fail++; $display("FAIL out_dnpc_ready got %b exp 1", O_dnpc_ready); end
    tick();
    I_IF_ID_ready = 0; I_dnpc_valid = 0; I_imem_req_ready = 0; #1;
    n_checks++; if (O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0010 || O_fetch_cnt !== 64'd1 || O_IF_ID_valid !== 1'b0) begin
      n_fail++; $display("FAIL both_hs got rqv=%b a=%h cnt=%0d ifv=%b exp 1 80000010 1 0", O_imem_req_valid, O_imem_addr, O_fetch_cnt, O_IF_ID_valid);
    end
  endtask

  task automatic test_idle();
    I_imem_req_ready = 1; tick();
    I_imem_req_ready = 0; I_imem_resp_valid = 1; I_imem_rdata = 32'h1234_5678; tick();
    I_imem_resp_valid = 0; I_IF_ID_ready = 1; tick();
    I_IF_ID_ready = 0; #1;
    n_checks++; if (O_IF_ID_valid !== 1'b0 || O_imem_req_valid !== 1'b0 || O_dnpc_ready !== 1'b1 || O_fetch_cnt !== 64'd2) begin
      n_fail++; $display("FAIL idle_enter got ifv=%b rqv=%b dr=%b cnt=%0d exp 0 0 1 2", O_IF_ID_valid, O_imem_req_valid, O_dnpc_ready, O_fetch_cnt);
    end
    tick(); tick();
    I_dnpc_valid = 1; I_dnpc = 32'h8000_0020; #1;
    n_checks++; if (O_dnpc_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b exp 1", O_dnpc_ready); end
    tick();
    I_dnpc_valid = 0; #1;
    n_checks++; if (O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0020) begin n_fail++; $display("FAIL idle_req got v=%b a=%h exp 1 80000020", O_imem_req_valid, O_imem_addr); end
  endtask

  task automatic test_flush_wait();
    I_imem_req_ready = 1; tick();
    I_imem_req_ready = 0; I_flush = 1; I_flush_pc = 32'h8000_0100; I_dnpc_valid = 1; #1;
    n_checks++; if (O_dnpc_ready !== 1'b0) begin n_fail++; $display("FAIL flush_wait_dr got %b exp 0", O_dnpc_ready); end
    tick();
    I_flush = 0; I_dnpc_valid = 0; #1;
    n_checks++; if (O_imem_req_valid !== 1'b0 || O_imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL drain_hold got v=%b a=%h exp 0 80000100", O_imem_req_valid, O_imem_addr); end
    tick();
    I_imem_resp_valid = 1; I_imem_rdata = 32'hDEAD_BEEF; tick();
    I_imem_resp_valid = 0; #1;
    n_checks++; if (O_IF_ID_valid !== 1'b0 || O_IF_ID_inst !== 32'h1234_5678 || O_IF_ID_pc !== 32'h8000_0010) begin
      n_fail++; $display("FAIL drain_discard got v=%b pc=%h inst=%h exp 0 80000010 12345678", O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_inst);
    end
    n_checks++; if (O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL drain_req got v=%b a=%h exp 1 80000100", O_imem_req_valid, O_imem_addr); end
  endtask

  task automatic test_flush_with_resp();
    I_imem_req_ready = 1; tick();
    I_imem_req_ready = 0; I_imem_resp_valid = 1; I_imem_rdata = 32'hCAFE_F00D;
    I_flush = 1; I_flush_pc = 32'h8000_0200; tick();
    I_imem_resp_valid = 0; I_flush = 0; #1;
    n_checks++; if (O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0200 || O_IF_ID_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_resp got rqv=%b a=%h ifv=%b exp 1 80000200 0", O_imem_req_valid, O_imem_addr, O_IF_ID_valid);
    end
  endtask

  task automatic test_flush_out();
    logic [63:0] cnt_s;
    I_imem_req_ready = 1; tick();
    I_imem_req_ready = 0; I_imem_resp_valid = 1; I_imem_rdata = 32'h0BAD_0BAD; tick();
    I_imem_resp_valid = 0; cnt_s = O_fetch_cnt;
    I_IF_ID_ready = 1; I_dnpc_valid = 1; I_dnpc = 32'h8000_0300;
    I_flush = 1; I_flush_pc = 32'h8000_0400; #1;
    n_checks++; if (O_dnpc_ready !== 1'b0) begin n_fail++; $display("FAIL flush_out_dr got %b exp 0", O_dnpc_ready); end
    tick();
    I_IF_ID_ready = 0; I_dnpc_valid = 0; I_flush = 0; #1;
    n_checks++; if (O_IF_ID_valid !== 1'b0 || O_fetch_cnt !== cnt_s || O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0400) begin
      n_fail++; $display("FAIL flush_out got ifv=%b cnt=%0d rqv=%b a=%h exp 0 %0d 1 80000400", O_IF_ID_valid, O_fetch_cnt, O_imem_req_valid, O_imem_addr, cnt_s);
    end
  endtask

  task automatic test_reset_midfetch();
    I_imem_req_ready = 1; tick();
    I_imem_req_ready = 0; I_rst = 1; tick();
    I_rst = 0; I_imem_resp_valid = 1; I_imem_rdata = 32'h5555_AAAA; #1;
    n_checks++; if (O_imem_req_valid !== 1'b1 || O_fetch_cnt !== 64'd0 || O_IF_ID_valid !== 1'b0 || O_imem_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL rst_mid got rqv=%b cnt=%0d ifv=%b a=%h exp 1 0 0 80000000", O_imem_req_valid, O_fetch_cnt, O_IF_ID_valid, O_imem_addr);
    end
    tick();
    I_imem_resp_valid = 0; #1;
    n_checks++; if (O_IF_ID_valid !== 1'b0 || O_imem_req_valid !== 1'b1 || O_IF_ID_inst !== 32'h0) begin
      n_fail++; $display("FAIL late_resp got ifv=%b rqv=%b inst=%h exp 0 1 0", O_IF_ID_valid, O_imem_req_valid, O_IF_ID_inst);
    end
  endtask

  // Model: fetch PC plus flags for "request to issue", "awaiting response",
  // "response to discard" and "instruction held for decode".
  task automatic test_random();
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_pend, m_outst, m_disc, m_hold;
    logic [63:0] m_cnt;
    logic        mem_busy;
    int          mem_dly;
    logic [31:0] mem_data;
    logic        m_idle, e_rqv, e_dr, rfire, still;
    idle_inputs();
    I_rst = 1; tick(); I_rst = 0;
    m_pc = 32'h8000_0000; m_pend = 1; m_outst = 0; m_disc = 0; m_hold = 0;
    m_cnt = '0; m_ifpc = '0; m_inst = '0; mem_busy = 0; mem_dly = 0; mem_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      I_imem_req_ready  = ($urandom_range(0, 9) < 7);
      I_IF_ID_ready     = ($urandom_range(0, 9) < 6);
      I_dnpc_valid      = $urandom_range(0, 1) == 1;
      I_dnpc            = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      I_flush           = ($urandom_range(0, 19) == 0);
      I_flush_pc        = $urandom;
      I_imem_resp_valid = mem_busy && (mem_dly == 0);
      I_imem_rdata      = I_imem_resp_valid ? mem_data : $urandom;
      #1;
      m_idle = !m_pend && !m_outst && !m_hold;
      e_rqv  = m_pend;
      e_dr   = !I_flush && (m_hold ? I_IF_ID_ready : m_idle);
      n_checks++; if (O_imem_req_valid !== e_rqv) begin n_fail++; $display("FAIL rnd_req_valid cyc %0d got %b exp %b", cyc, O_imem_req_valid, e_rqv); end
      n_checks++; if (O_imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, O_imem_addr, m_pc); end
      n_checks++; if (O_dnpc_ready !== e_dr) begin n_fail++; $display("FAIL rnd_dnpc_ready cyc %0d got %b exp %b", cyc, O_dnpc_ready, e_dr); end
      n_checks++; if (O_IF_ID_valid !== m_hold) begin n_fail++; $display("FAIL rnd_ifid_valid cyc %0d got %b exp %b", cyc, O_IF_ID_valid, m_hold); end
      n_checks++; if (O_fetch_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", cyc, O_fetch_cnt, m_cnt); end
      if (m_hold) begin
        n_checks++; if (O_IF_ID_pc !== m_ifpc || O_IF_ID_snpc !== m_ifpc + 32'd4 || O_IF_ID_inst !== m_inst) begin
          n_fail++; $display("FAIL rnd_ifid cyc %0d got %h %h %h exp %h %h %h", cyc, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, m_ifpc, m_ifpc + 32'd4, m_inst);
        end
      end
      rfire = m_pend && I_imem_req_ready;
      if (I_flush) begin
        still   = (m_outst && !I_imem_resp_valid) || rfire;
        m_pc    = I_flush_pc;
        m_hold  = 0;
        m_outst = still;
        m_disc  = still;
        m_pend  = !still;
      end else if (rfire) begin
        m_pend = 0; m_outst = 1; m_disc = 0;
      end else if (m_outst && I_imem_resp_valid) begin
        m_outst = 0;
        if (m_disc) m_pend = 1;
        else begin m_hold = 1; m_ifpc = m_pc; m_inst = I_imem_rdata; end
      end else if (m_hold && I_IF_ID_ready) begin
        m_hold = 0; m_cnt = m_cnt + 64'd1;
        if (I_dnpc_valid) begin m_pc = I_dnpc; m_pend = 1; end
      end else if (m_idle && I_dnpc_valid) begin
        m_pc = I_dnpc; m_pend = 1;
      end
      if (rfire) begin
        mem_busy = 1; mem_dly = $urandom_range(0, 2); mem_data = $urandom;
      end else if (mem_busy) begin
        if (mem_dly == 0) mem_busy = 0;
        else mem_dly--;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    I_rst = 1;
    test_reset();
    test_fetch_and_stall();
    test_idle();
    test_flush_wait();
    test_flush_with_resp();
    test_flush_out();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_ifu.md
# ysyx_22040750_ifu

Instruction fetch unit of the full-pipeline core: owns the architectural fetch PC, accepts the next PC (dnpc) from the next-PC generator over a valid/ready handshake, issues one instruction-memory request per PC, and delivers {pc, snpc, inst} to the IF/ID boundary. It is the consuming end of the dnpc handshake. It also handles trap/interrupt redirects, including discarding an in-flight fetch.

## Interface
- RESET_PC, 32'h8000_0000, fetch address after reset
- I_clk  in  1  clock
- I_rst  in  1  reset; synchronous, active-high
- I_dnpc_valid  in  1  next-PC generator offers I_dnpc
- O_dnpc_ready  out  1  IFU accepts a dnpc this cycle
- I_dnpc  in  32  next fetch PC
- I_flush  in  1  redirect (trap/interrupt/mret); priority over everything
- I_flush_pc  in  32  redirect target
- O_imem_req_valid  out  1  fetch request
- I_imem_req_ready  in  1  memory accepts request
- O_imem_addr  out  32  fetch address (= PC register)
- I_imem_resp_valid  in  1  instruction returned
- I_imem_rdata  in  32  instruction word
- O_IF_ID_valid  out  1  fetched instruction available
- I_IF_ID_ready  in  1  decode consumes it
- O_IF_ID_pc / O_IF_ID_snpc / O_IF_ID_inst  out  32 each  pc, pc+4, instruction
- O_fetch_cnt  out  64  instructions delivered to decode (IF_ID handshakes)

## Operation
- States: REQ, WAIT, OUT, IDLE, DRAIN. One fetch outstanding max.
- REQ: O_imem_req_valid=1, addr=PC. Req handshake -> WAIT.
- WAIT: on I_imem_resp_valid capture pc, pc+4 (mod 2^32), rdata into IF_ID regs, set O_IF_ID_valid -> OUT.
- OUT: O_IF_ID_valid=1. IF_ID handshake clears valid, increments O_fetch_cnt. O_dnpc_ready = I_IF_ID_ready. IF_ID and dnpc handshakes together: PC<=I_dnpc -> REQ. IF_ID only -> IDLE. dnpc never accepted while IF_ID held.
- IDLE: O_dnpc_ready=1; dnpc handshake: PC<=I_dnpc -> REQ.
- O_dnpc_ready=0 in REQ, WAIT, DRAIN. I_dnpc low bits passed unchanged.
- Flush (any state): PC<=I_flush_pc, O_IF_ID_valid<=0, any dnpc handshake that cycle ignored (dnpc_ready forced 0), no fetch_cnt increment. Next state: DRAIN if a request is outstanding without its response (in WAIT with no resp this cycle, in REQ with req handshake this cycle, or already in DRAIN with no resp); otherwise REQ.
- DRAIN: wait for response, discard it (IF_ID regs untouched) -> REQ. Flush in DRAIN only updates PC (and goes REQ if the response arrives that cycle).
- O_imem_addr may change while req is pending unaccepted (flush in REQ); imem is SRAM-like, this is legal.
- O_fetch_cnt wraps at 2^64.

## Timing
- Reset: state REQ, PC=RESET_PC, O_imem_req_valid=0 while I_rst=1, 1 from first cycle after; O_IF_ID_valid=0, pc/snpc/inst=0, O_fetch_cnt=0, O_dnpc_ready=0.
- O_imem_req_valid, O_dnpc_ready, O_imem_addr are combinational from state/PC/I_IF_ID_ready/I_flush; no I_dnpc_valid->O_dnpc_ready path.
- Response accepted in cycle N -> O_IF_ID_valid high from N+1.
- Zero-wait memory (ready=1, resp next cycle), decode always ready, dnpc valid at once: new instruction every 3 cycles (REQ, WAIT, OUT).
- Reset mid-fetch: all state cleared; a late response after reset arrives in REQ and is ignored.

## Test plan
- Reset then ready memory returning 32'h00000413: req at 0x80000000 one cycle after reset; O_IF_ID_valid, pc=0x80000000, snpc=0x80000004, inst=0x00000413 one cycle after resp.
- Decode stalls 4 cycles with dnpc_valid=1, I_dnpc=0x80000010: O_dnpc_ready=0, outputs stable; on ready, both handshakes same cycle, next req addr 0x80000010, O_fetch_cnt=1.
- Decode consumes while dnpc_valid=0 -> IDLE; dnpc 0x80000020 three cycles later accepted immediately, req next cycle.
- Flush to 0x80000100 in WAIT; response 2 cycles later discarded (IF_ID valid stays 0); next req addr 0x80000100.
- Flush coinciding with response in WAIT: response dropped, req to flush_pc next cycle, no DRAIN.
- Flush in OUT with IF_ID and dnpc handshake same cycle: O_IF_ID_valid cleared, O_fetch_cnt unchanged, dnpc ignored, req addr=flush_pc.
